// File: rtl/fpnew_pkg.sv
// Shared FP types used by the div/sqrt datapath and its issue queue.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 5;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL,
        DIV, SQRT,
        SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

endpackage

// File: rtl/fpnew_fifo_ctrl.sv
// Pointer/count bookkeeping for a power-of-two FIFO with flush; storage lives in the user.
module fpnew_fifo_ctrl #(
    parameter int unsigned Depth = 4,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned PtrW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [AddrW-1:0] wr_addr_o,
    output logic [AddrW-1:0] rd_addr_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW-1:0]  count_o
);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("fpnew_fifo_ctrl: Depth must be a power of two >= 2");
    end

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] count_q,  count_d;
    logic            push_ok, pop_ok;

    // The extra MSB on each pointer tells full from empty when the low bits match.
    assign full_o    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign wr_addr_o = wr_ptr_q[AddrW-1:0];
    assign rd_addr_o = rd_ptr_q[AddrW-1:0];
    assign count_o   = count_q;

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + PtrW'(1);
                2'b01:   count_d = count_q - PtrW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_no_push_when_full : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !flush_i));

endmodule

// File: rtl/fpnew_divsqrt_issue_queue.sv
// Request queue in front of the iterative div/sqrt unit.
// Optional zero-latency bypass when empty: define FPNEW_DIVSQRT_QUEUE_BYPASS_EN.
module fpnew_divsqrt_issue_queue
    import fpnew_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned Width   = 64,
    parameter type         TagType = logic,
    parameter type         AuxType = logic,
    localparam int unsigned CntW   = $clog2(Depth) + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [1:0][Width-1:0]            operands_i,
    input  logic [NUM_FP_FORMATS-1:0][1:0]   is_boxed_i,
    input  roundmode_e                       rnd_mode_i,
    input  operation_e                       op_i,
    input  fp_format_e                       dst_fmt_i,
    input  TagType                           tag_i,
    input  AuxType                           aux_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic                             flush_i,
    output logic [1:0][Width-1:0]            operands_o,
    output logic [NUM_FP_FORMATS-1:0][1:0]   is_boxed_o,
    output roundmode_e                       rnd_mode_o,
    output operation_e                       op_o,
    output fp_format_e                       dst_fmt_o,
    output TagType                           tag_o,
    output AuxType                           aux_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [CntW-1:0]                  occupancy_o,
    output logic                             busy_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    typedef struct packed {
        logic [1:0][Width-1:0]           operands;
        logic [NUM_FP_FORMATS-1:0][1:0]  is_boxed;
        roundmode_e                      rnd_mode;
        operation_e                      op;
        fp_format_e                      dst_fmt;
        TagType                          tag;
        AuxType                          aux;
    } queue_entry_t;

    queue_entry_t             mem_q [Depth];
    queue_entry_t             mem_d [Depth];
    queue_entry_t             in_entry, head_entry, sel_entry, out_entry;
    logic [AddrW-1:0]         wr_addr, rd_addr;
    logic                     full, empty;
    logic                     bypass_en;
    logic                     push_en, pop_en;

    fpnew_fifo_ctrl #(.Depth(Depth)) i_fifo_ctrl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .push_i    (push_en),
        .pop_i     (pop_en),
        .wr_addr_o (wr_addr),
        .rd_addr_o (rd_addr),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (occupancy_o)
    );

    always_comb begin
        in_entry.operands = operands_i;
        in_entry.is_boxed = is_boxed_i;
        in_entry.rnd_mode = rnd_mode_i;
        in_entry.op       = op_i;
        in_entry.dst_fmt  = dst_fmt_i;
        in_entry.tag      = tag_i;
        in_entry.aux      = aux_i;
    end

    assign head_entry = mem_q[rd_addr];

    // Handshake: a beat transfers on an edge where valid & ready are both high.
    // in_ready_o never looks at out_ready_i, so a full queue refuses a push even
    // when the head pops in the same cycle. Flush and reset drop both valid and ready.
    assign in_ready_o = ~full & ~flush_i & ~rst_i;

`ifdef FPNEW_DIVSQRT_QUEUE_BYPASS_EN
    assign bypass_en   = empty & in_valid_i & out_ready_i & ~flush_i & ~rst_i;
    assign out_valid_o = (~empty | bypass_en) & ~flush_i & ~rst_i;
    assign sel_entry   = bypass_en ? in_entry : head_entry;
`else
    assign bypass_en   = 1'b0;
    assign out_valid_o = ~empty & ~flush_i & ~rst_i;
    assign sel_entry   = head_entry;
`endif

    // A bypassed request is consumed directly and must not touch storage or pointers.
    assign push_en = in_valid_i & in_ready_o & ~bypass_en;
    assign pop_en  = out_valid_o & out_ready_i & ~bypass_en;

    assign out_entry = out_valid_o ? sel_entry : queue_entry_t'('0);

    always_comb begin
        operands_o = out_entry.operands;
        is_boxed_o = out_entry.is_boxed;
        rnd_mode_o = out_entry.rnd_mode;
        op_o       = out_entry.op;
        dst_fmt_o  = out_entry.dst_fmt;
        tag_o      = out_entry.tag;
        aux_o      = out_entry.aux;
    end

    assign busy_o = (occupancy_o != '0);

    always_comb begin
        for (int i = 0; i < int'(Depth); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_en) begin
            mem_d[wr_addr] = in_entry;
        end
    end

    // Storage is deliberately not reset; outputs are masked by out_valid_o instead.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
// Directed bench for fpnew_divsqrt_issue_queue: fill/full, wrap, flush, reset, bypass.
module tb_fpnew_divsqrt_issue_queue;
    import fpnew_pkg::*;

    localparam int unsigned Depth = 4;
    localparam int unsigned Width = 64;
`ifdef FPNEW_DIVSQRT_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                            clk;
    logic                            rst;
    logic [1:0][Width-1:0]           operands_in;
    logic [NUM_FP_FORMATS-1:0][1:0]  is_boxed_in;
    roundmode_e                      rnd_mode_in;
    operation_e                      op_in;
    fp_format_e                      dst_fmt_in;
    logic [7:0]                      tag_in;
    logic [3:0]                      aux_in;
    logic                            in_valid;
    logic                            in_ready;
    logic                            flush;
    logic [1:0][Width-1:0]           operands_out;
    logic [NUM_FP_FORMATS-1:0][1:0]  is_boxed_out;
    roundmode_e                      rnd_mode_out;
    operation_e                      op_out;
    fp_format_e                      dst_fmt_out;
    logic [7:0]                      tag_out;
    logic [3:0]                      aux_out;
    logic                            out_valid;
    logic                            out_ready;
    logic [2:0]                      occupancy;
    logic                            busy;

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    fpnew_divsqrt_issue_queue #(
        .Depth   (Depth),
        .Width   (Width),
        .TagType (logic [7:0]),
        .AuxType (logic [3:0])
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .operands_i  (operands_in),
        .is_boxed_i  (is_boxed_in),
        .rnd_mode_i  (rnd_mode_in),
        .op_i        (op_in),
        .dst_fmt_i   (dst_fmt_in),
        .tag_i       (tag_in),
        .aux_i       (aux_in),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .flush_i     (flush),
        .operands_o  (operands_out),
        .is_boxed_o  (is_boxed_out),
        .rnd_mode_o  (rnd_mode_out),
        .op_o        (op_out),
        .dst_fmt_o   (dst_fmt_out),
        .tag_o       (tag_out),
        .aux_o       (aux_out),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .occupancy_o (occupancy),
        .busy_o      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks; the bench always sits just after a falling edge
    task automatic drive(input logic v, input logic [7:0] t, input logic rdy, input logic fl);
        in_valid    = v;
        tag_in      = t;
        aux_in      = t[3:0];
        operands_in = {{56'h0, t}, 64'hA5A5_0000_0000_0000 | {56'h0, t}};
        out_ready   = rdy;
        flush       = fl;
    endtask

    // scoreboard hook runs before each rising edge
    task automatic step();
        #1;
        if (in_valid && in_ready) exp_q.push_back(tag_in);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", 64'(tag_out), 64'hFFFF);
            else check("pop_tag", 64'(tag_out), 64'(exp_q.pop_front()));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        is_boxed_in = '1;
        rnd_mode_in = RNE;
        op_in       = DIV;
        dst_fmt_in  = FP64;
        drive(1'b0, 8'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 1);
        check("post_rst_out_valid", 64'(out_valid), 0);
        check("post_rst_occ", 64'(occupancy), 0);
        check("post_rst_busy", 64'(busy), 0);

        // three DIV requests, unit not ready
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h0, 1'b0, 1'b0);
        #1;
        check("fill3_occ", 64'(occupancy), 3);
        check("fill3_valid", 64'(out_valid), 1);
        check("fill3_tag", 64'(tag_out), 1);
        check("fill3_busy", 64'(busy), 1);
        check("fill3_op", 64'(op_out), 64'(DIV));

        // fourth fills the queue, fifth is refused even alongside a pop
        drive(1'b1, 8'd4, 1'b0, 1'b0);
        #1;
        check("push4_ready", 64'(in_ready), 1);
        step();
        check("full_ready", 64'(in_ready), 0);
        check("full_occ", 64'(occupancy), 4);
        drive(1'b1, 8'd5, 1'b0, 1'b0);
        step();
        check("full_hold_occ", 64'(occupancy), 4);
        drive(1'b1, 8'd5, 1'b1, 1'b0);
        #1;
        check("full_pop_ready", 64'(in_ready), 0);
        step();
        drive(1'b0, 8'h0, 1'b0, 1'b0);
        #1;
        check("after_pop_occ", 64'(occupancy), 3);
        check("after_pop_ready", 64'(in_ready), 1);
        check("after_pop_tag", 64'(tag_out), 2);
        drive(1'b0, 8'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("drained_valid", 64'(out_valid), 0);
        check("drained_busy", 64'(busy), 0);

        // streaming through the wrap point
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, 8'(i), 1'b1, 1'b0);
            step();
            check("stream_occ", 64'(occupancy), (i < 10 && !BYPASS) ? 1 : 0);
        end
        check("stream_sb_empty", 64'(exp_q.size()), 0);

        // flush with a concurrent offer
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'd7, 1'b1, 1'b1);
        #1;
        check("flush_ready", 64'(in_ready), 0);
        check("flush_valid", 64'(out_valid), 0);
        check("flush_tag_zero", 64'(tag_out), 0);
        step();
        exp_q.delete();
        drive(1'b0, 8'h0, 1'b0, 1'b0);
        #1;
        check("post_flush_occ", 64'(occupancy), 0);
        check("post_flush_valid", 64'(out_valid), 0);
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h0, 1'b1, 1'b0);
        #1;
        check("post_flush_head", 64'(tag_out), 64'h20);
        step();

        // reset in the middle of traffic
        drive(1'b0, 8'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
            step();
        end
        rst = 1'b1;
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        #1;
        check("mid_rst_ready", 64'(in_ready), 0);
        check("mid_rst_valid", 64'(out_valid), 0);
        step();
        step();
        exp_q.delete();
        rst = 1'b0;
        drive(1'b0, 8'h0, 1'b0, 1'b0);
        #1;
        check("rst2_occ", 64'(occupancy), 0);
        check("rst2_valid", 64'(out_valid), 0);
        check("rst2_ready", 64'(in_ready), 1);
        check("rst2_tag", 64'(tag_out), 0);
        check("rst2_op0", operands_out[0], 0);
        check("rst2_op1", operands_out[1], 0);

        // empty queue, unit ready: bypass or one-cycle latency
        drive(1'b1, 8'd5, 1'b1, 1'b0);
        #1;
        check("byp_valid", 64'(out_valid), BYPASS ? 1 : 0);
        check("byp_tag", 64'(tag_out), BYPASS ? 5 : 0);
        check("byp_aux", 64'(aux_out), BYPASS ? 5 : 0);
        step();
        drive(1'b0, 8'h0, 1'b1, 1'b0);
        #1;
        check("byp_occ", 64'(occupancy), BYPASS ? 0 : 1);
        check("byp_late_valid", 64'(out_valid), BYPASS ? 0 : 1);
        check("byp_late_tag", 64'(tag_out), BYPASS ? 0 : 5);
        check("byp_late_opnd0", operands_out[0], BYPASS ? 64'h0 : 64'hA5A5_0000_0000_0005);
        step();
        check("final_occ", 64'(occupancy), 0);
        check("final_sb_empty", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
